// File: rtl/drive_seq_pkg.sv
// Shared types and widths for the drive sequencer: FSM state encoding and bus widths.
package drive_seq_pkg;

   localparam int unsigned ERR_W       = 48;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_WAIT_RESULT,
      ST_FAULT
   } seq_state_e;

endpackage

// File: rtl/drive_sequencer_err_clamp.sv
// Symmetric signed saturation of the CNN lane error to [-LIMIT, +LIMIT].
module err_clamp
   import drive_seq_pkg::*;
#(
   parameter logic signed [ERR_W-1:0] LIMIT = 48'sh0000_7FFF_FFFF
) (
   input  logic signed [ERR_W-1:0] err,
   output logic signed [ERR_W-1:0] clamped_c
);

   localparam logic signed [ERR_W-1:0] NEG_LIMIT = -LIMIT;

   // Both operands are 48-bit signed, so the compare never wraps.
   always_comb begin
      clamped_c = err;
      if (err > LIMIT) begin
         clamped_c = LIMIT;
      end else if (err < NEG_LIMIT) begin
         clamped_c = NEG_LIMIT;
      end
   end

endmodule

// File: rtl/drive_sequencer.sv
// Frame-to-CNN-to-PID sequencer with result timeout, miss counting and FAULT lockout.
// Build option: SEQ_HOLD_LAST_EN re-issues the last PID error after each non-fatal timeout.
module drive_sequencer
   import drive_seq_pkg::*;
#(
   parameter int unsigned             FRAME_PIXELS   = 1024,
   parameter int unsigned             TIMEOUT_CYCLES = 4096,
   parameter logic signed [ERR_W-1:0] ERR_LIMIT      = 48'sh0000_7FFF_FFFF,
   parameter int unsigned             MAX_MISSES     = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_enable,
   input  logic                          i_frame_sync,
   input  logic                          i_pixel_valid,
   output logic                          o_cnn_start,
   input  logic                          i_cnn_valid,
   input  logic signed [ERR_W-1:0]       i_cnn_error,
   output logic                          o_pid_valid,
   output logic signed [ERR_W-1:0]       o_pid_error,
   output logic                          o_busy,
   output logic                          o_timeout,
   output logic                          o_fault,
   output logic [FRAME_CNT_W-1:0]        o_frame_cnt
);

   localparam int unsigned PIX_W  = (FRAME_PIXELS > 1)   ? $clog2(FRAME_PIXELS)   : 1;
   localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1) > 0 ? $clog2(MAX_MISSES + 1) : 1;

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_PIXELS - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISSES - 1);

   seq_state_e               state;
   logic [PIX_W-1:0]         pix_cnt;
   logic [TMR_W-1:0]         timer;
   logic [MISS_W-1:0]        miss_cnt;
   logic signed [ERR_W-1:0]  clamped_c;

   err_clamp #(
      .LIMIT (ERR_LIMIT)
   ) u_err_clamp (
      .err       (i_cnn_error),
      .clamped_c (clamped_c)
   );

`ifdef SEQ_HOLD_LAST_EN
   logic hold_pend;
`endif

   // Sequencer FSM; pulse outputs default low each cycle and are set on the transition edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pix_cnt     <= '0;
         timer       <= '0;
         miss_cnt    <= '0;
         o_cnn_start <= 1'b0;
         o_pid_valid <= 1'b0;
         o_pid_error <= '0;
         o_busy      <= 1'b0;
         o_timeout   <= 1'b0;
         o_fault     <= 1'b0;
         o_frame_cnt <= '0;
`ifdef SEQ_HOLD_LAST_EN
         hold_pend   <= 1'b0;
`endif
      end else begin
         o_cnn_start <= 1'b0;
         o_timeout   <= 1'b0;
`ifdef SEQ_HOLD_LAST_EN
         o_pid_valid <= hold_pend;
         hold_pend   <= 1'b0;
`else
         o_pid_valid <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (i_enable && i_frame_sync) begin
                  state       <= ST_CAPTURE;
                  pix_cnt     <= '0;
                  o_cnn_start <= 1'b1;
                  o_busy      <= 1'b1;
               end
            end

            ST_CAPTURE: begin
               if (!i_enable) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else if (i_pixel_valid) begin
                  if (pix_cnt == PIX_LAST) begin
                     state <= ST_WAIT_RESULT;
                     timer <= '0;
                  end else begin
                     pix_cnt <= pix_cnt + PIX_W'(1);
                  end
               end
            end

            // Abort outranks a result, and a result outranks the timer expiring.
            ST_WAIT_RESULT: begin
               if (!i_enable) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else if (i_cnn_valid) begin
                  state       <= ST_IDLE;
                  o_busy      <= 1'b0;
                  o_pid_error <= clamped_c;
                  o_pid_valid <= 1'b1;
                  miss_cnt    <= '0;
                  o_frame_cnt <= o_frame_cnt + FRAME_CNT_W'(1);
               end else if (timer == TMR_LAST) begin
                  o_timeout <= 1'b1;
                  o_busy    <= 1'b0;
                  miss_cnt  <= miss_cnt + MISS_W'(1);
                  if (miss_cnt == MISS_LAST) begin
                     state   <= ST_FAULT;
                     o_fault <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
`ifdef SEQ_HOLD_LAST_EN
                     hold_pend <= 1'b1;
`endif
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            ST_FAULT: begin
               if (!i_enable) begin
                  state    <= ST_IDLE;
                  o_fault  <= 1'b0;
                  miss_cnt <= '0;
               end
            end

            default: begin
               state   <= ST_IDLE;
               o_busy  <= 1'b0;
               o_fault <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer: clamp vector table, timing corner sequences, and
// randomized frames scored against a transaction-level model.
module tb_drive_sequencer;

   localparam int unsigned FP  = 16;
   localparam int unsigned TO  = 20;
   localparam int unsigned MM  = 3;
`ifdef SEQ_HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic               i_enable;
   logic               i_frame_sync;
   logic               i_pixel_valid;
   logic               o_cnn_start;
   logic               i_cnn_valid;
   logic signed [47:0] i_cnn_error;
   logic               o_pid_valid;
   logic signed [47:0] o_pid_error;
   logic               o_busy;
   logic               o_timeout;
   logic               o_fault;
   logic [15:0]        o_frame_cnt;

   drive_sequencer #(
      .FRAME_PIXELS   (FP),
      .TIMEOUT_CYCLES (TO),
      .ERR_LIMIT      (48'sd1000),
      .MAX_MISSES     (MM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (i_enable),
      .i_frame_sync  (i_frame_sync),
      .i_pixel_valid (i_pixel_valid),
      .o_cnn_start   (o_cnn_start),
      .i_cnn_valid   (i_cnn_valid),
      .i_cnn_error   (i_cnn_error),
      .o_pid_valid   (o_pid_valid),
      .o_pid_error   (o_pid_error),
      .o_busy        (o_busy),
      .o_timeout     (o_timeout),
      .o_fault       (o_fault),
      .o_frame_cnt   (o_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Pulse monitor: counts output pulses, cleared while reset is held.
   int                 mon_start;
   int                 mon_pid;
   int                 mon_to;
   logic signed [63:0] mon_pid_err;
   always @(negedge clk) begin
      if (rst) begin
         mon_start   = 0;
         mon_pid     = 0;
         mon_to      = 0;
         mon_pid_err = 0;
      end else begin
         if (o_cnn_start) mon_start++;
         if (o_timeout)   mon_to++;
         if (o_pid_valid) begin
            mon_pid++;
            mon_pid_err = 64'(o_pid_error);
         end
      end
   end

   // Reference model state (transaction level).
   int                 m_start;
   int                 m_pid;
   int                 m_to;
   int                 m_miss;
   int                 m_frames;
   bit                 m_fault;
   logic signed [63:0] m_err;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [63:0] clamp(input logic signed [63:0] v);
      if (v > 1000)  return 1000;
      if (v < -1000) return -1000;
      return v;
   endfunction

   task automatic do_reset();
      rst           = 1'b1;
      i_enable      = 1'b1;
      i_frame_sync  = 1'b0;
      i_pixel_valid = 1'b0;
      i_cnn_valid   = 1'b0;
      i_cnn_error   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_start = 0; m_pid = 0; m_to = 0; m_miss = 0; m_frames = 0; m_fault = 0; m_err = 0;
   endtask

   task automatic pixels(input int n);
      i_pixel_valid = 1'b1;
      repeat (n) @(negedge clk);
      i_pixel_valid = 1'b0;
   endtask

   task automatic sync_pulse();
      i_frame_sync = 1'b1;
      @(negedge clk);
      i_frame_sync = 1'b0;
   endtask

   // One frame transaction: d = result delay after the last pixel (>TO means none in time),
   // abort_pix = pixel index where enable drops (-1 none), abort_k = wait cycle of enable drop (0 none).
   task automatic do_frame(input int d, input logic signed [63:0] err, input int abort_pix,
                           input int abort_k, input bit noise);
      bit was_fault;
      bit stray_ok;
      bit aborted_cap;
      int end_k;
      was_fault   = m_fault;
      stray_ok    = 1'b1;
      aborted_cap = 1'b0;
      sync_pulse();
      for (int p = 0; p < int'(FP); p++) begin
         if (noise) begin
            repeat ($urandom_range(0, 2)) begin
               i_frame_sync = stray_ok && ($urandom_range(0, 3) == 0);
               @(negedge clk);
               i_frame_sync = 1'b0;
            end
         end
         if (p == abort_pix && !was_fault) begin
            i_enable = 1'b0;
            @(negedge clk);
            i_enable    = 1'b1;
            stray_ok    = 1'b0;
            aborted_cap = 1'b1;
         end
         pixels(1);
      end
      end_k = (d < int'(TO)) ? d : int'(TO);
      if (abort_k > 0 && abort_k < end_k) end_k = abort_k;
      i_cnn_error = 48'(err);
      for (int k = 1; k <= 26; k++) begin
         i_cnn_valid = (k == d) || (k == d + 3);
         i_enable    = !(k == abort_k && !was_fault && !aborted_cap);
         if (noise) begin
            i_pixel_valid = 1'($urandom_range(0, 1));
            i_frame_sync  = stray_ok && (k < end_k) && ($urandom_range(0, 5) == 0);
         end
         @(negedge clk);
      end
      i_cnn_valid   = 1'b0;
      i_enable      = 1'b1;
      i_pixel_valid = 1'b0;
      i_frame_sync  = 1'b0;
      repeat (3) @(negedge clk);

      if (!was_fault) begin
         m_start++;
         if (aborted_cap) begin
         end else if (abort_k > 0 && abort_k <= ((d < int'(TO)) ? d : int'(TO))) begin
         end else if (d <= int'(TO)) begin
            m_pid++;
            m_err    = clamp(err);
            m_frames = (m_frames + 1) % 65536;
            m_miss   = 0;
         end else begin
            m_to++;
            m_miss++;
            if (m_miss >= int'(MM)) m_fault = 1'b1;
            else if (HOLD)          m_pid++;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_start_cnt"}, 64'(mon_start), 64'(m_start));
      check({tag, "_pid_cnt"},   64'(mon_pid),   64'(m_pid));
      check({tag, "_to_cnt"},    64'(mon_to),    64'(m_to));
      check({tag, "_pid_err"},   64'(o_pid_error), m_err);
      check({tag, "_frames"},    64'(o_frame_cnt), 64'(m_frames));
      check({tag, "_fault"},     64'(o_fault),   64'(m_fault));
      check({tag, "_busy"},      64'(o_busy),    64'd0);
   endtask

   typedef struct {
      logic signed [63:0] err;
      logic signed [63:0] exp;
   } vec_t;
   vec_t tbl[10];

   int first_to;
   int to_cnt;
   int pid_k;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      tbl[0] = '{-250, -250};
      tbl[1] = '{5000, 1000};
      tbl[2] = '{-5000, -1000};
      tbl[3] = '{1000, 1000};
      tbl[4] = '{1001, 1000};
      tbl[5] = '{-1000, -1000};
      tbl[6] = '{-1001, -1000};
      tbl[7] = '{0, 0};
      tbl[8] = '{64'sh0000_7FFF_FFFF_FFFF, 1000};
      tbl[9] = '{-64'sh0000_8000_0000_0000, -1000};

      // Reset state, sampled while reset is still asserted.
      rst = 1'b1; i_enable = 1'b1; i_frame_sync = 1'b0; i_pixel_valid = 1'b0;
      i_cnn_valid = 1'b0; i_cnn_error = '0;
      repeat (2) @(negedge clk);
      check("rst_cnn_start", 64'(o_cnn_start), 0);
      check("rst_pid_valid", 64'(o_pid_valid), 0);
      check("rst_pid_error", 64'(o_pid_error), 0);
      check("rst_busy",      64'(o_busy),      0);
      check("rst_timeout",   64'(o_timeout),   0);
      check("rst_fault",     64'(o_fault),     0);
      check("rst_frame_cnt", 64'(o_frame_cnt), 0);
      do_reset();

      // Nominal frame with exact pulse timing.
      sync_pulse();
      check("nom_start_pulse", 64'(o_cnn_start), 1);
      check("nom_busy", 64'(o_busy), 1);
      pixels(FP);
      repeat (4) @(negedge clk);
      check("nom_still_waiting", 64'(o_busy), 1);
      i_cnn_error = -48'sd250;
      i_cnn_valid = 1'b1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      check("nom_pid_valid", 64'(o_pid_valid), 1);
      check("nom_pid_error", 64'(o_pid_error), -250);
      check("nom_frame_cnt", 64'(o_frame_cnt), 1);
      @(negedge clk);
      check("nom_pid_valid_low", 64'(o_pid_valid), 0);
      check("nom_pid_error_hold", 64'(o_pid_error), -250);
      check("nom_start_count", 64'(mon_start), 1);

      // Timeout: pulse exactly 20 cycles after the last pixel.
      sync_pulse();
      pixels(FP);
      first_to = 0; to_cnt = 0; pid_k = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (o_timeout) begin
            to_cnt++;
            if (first_to == 0) first_to = k;
         end
         if (o_pid_valid) pid_k = k;
      end
      check("to_cycle", 64'(first_to), 20);
      check("to_count", 64'(to_cnt), 1);
      check("to_hold_pid_cycle", 64'(pid_k), HOLD ? 21 : 0);
      check("to_pid_error_hold", 64'(o_pid_error), -250);
      check("to_frame_cnt", 64'(o_frame_cnt), 1);

      // Result on the expiry cycle wins over the timeout.
      sync_pulse();
      pixels(FP);
      repeat (19) @(negedge clk);
      i_cnn_error = 48'sd700;
      i_cnn_valid = 1'b1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      check("col_pid_valid", 64'(o_pid_valid), 1);
      check("col_timeout", 64'(o_timeout), 0);
      check("col_pid_error", 64'(o_pid_error), 700);
      repeat (3) @(negedge clk);
      check("col_to_total", 64'(mon_to), 1);
      check("col_frame_cnt", 64'(o_frame_cnt), 2);

      // Three consecutive timeouts lock into FAULT until enable drops.
      do_reset();
      for (int t = 0; t < 3; t++) begin
         sync_pulse();
         pixels(FP);
         repeat (24) @(negedge clk);
      end
      check("flt_fault", 64'(o_fault), 1);
      check("flt_busy", 64'(o_busy), 0);
      check("flt_to_count", 64'(mon_to), 3);
      sync_pulse();
      check("flt_sync_ignored", 64'(o_cnn_start), 0);
      check("flt_still_fault", 64'(o_fault), 1);
      i_enable = 1'b0;
      @(negedge clk);
      i_enable = 1'b1;
      check("flt_exit", 64'(o_fault), 0);
      sync_pulse();
      check("flt_restart", 64'(o_cnn_start), 1);

      // Enable dropped at pixel 8 aborts with no result.
      do_reset();
      sync_pulse();
      pixels(8);
      i_enable = 1'b0;
      @(negedge clk);
      i_enable = 1'b1;
      check("abt_busy", 64'(o_busy), 0);
      pixels(8);
      repeat (3) @(negedge clk);
      i_cnn_error = 48'sd123;
      i_cnn_valid = 1'b1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abt_pid_count", 64'(mon_pid), 0);
      check("abt_frame_cnt", 64'(o_frame_cnt), 0);
      check("abt_start_count", 64'(mon_start), 1);

      // Reset during WAIT_RESULT clears everything; a late result is ignored.
      do_reset();
      sync_pulse();
      pixels(FP);
      repeat (4) @(negedge clk);
      i_cnn_error = -48'sd250;
      i_cnn_valid = 1'b1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      sync_pulse();
      pixels(FP);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("rmw_pid_error", 64'(o_pid_error), 0);
      check("rmw_frame_cnt", 64'(o_frame_cnt), 0);
      check("rmw_busy",      64'(o_busy),      0);
      check("rmw_pid_valid", 64'(o_pid_valid), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      i_cnn_valid = 1'b1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rmw_late_pid", 64'(mon_pid), 0);
      check("rmw_late_frames", 64'(o_frame_cnt), 0);

      // Clamp vector table, one frame per entry.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         do_frame(5, tbl[i].err, -1, 0, 1'b0);
         check($sformatf("vec%0d_pid_error", i), 64'(o_pid_error), tbl[i].exp);
         check($sformatf("vec%0d_frames", i), 64'(o_frame_cnt), 64'(i + 1));
      end

      // Randomized frames against the model.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         int                 d;
         int                 ap;
         int                 ak;
         logic [47:0]        raw;
         logic signed [63:0] e;
         d  = int'($urandom_range(1, 26));
         ap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FP - 1)) : -1;
         ak = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TO)) : 0;
         if ($urandom_range(0, 4) == 0) begin
            raw = 48'({$urandom(), $urandom()});
            e   = 64'($signed(raw));
         end else begin
            e = 64'($signed(32'($urandom_range(0, 6000)))) - 64'sd3000;
         end
         do_frame(d, e, ap, ak, 1'b1);
         check_model($sformatf("rnd%0d", n));
         if (m_fault && $urandom_range(0, 1) == 1) begin
            i_enable = 1'b0;
            @(negedge clk);
            i_enable = 1'b1;
            m_fault  = 1'b0;
            m_miss   = 0;
            check($sformatf("rnd%0d_recover", n), 64'(o_fault), 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter FRAME_PIXELS, default 1024; pixels per camera frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096; maximum cycles allowed from the last pixel to a CNN result.
REQ-003 Parameter ERR_LIMIT, default 48'sh0000_7FFF_FFFF; symmetric saturation bound applied to the CNN error.
REQ-004 Parameter MAX_MISSES, default 3; number of consecutive timeouts that forces FAULT.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 i_enable  input  1  level; sequencer runs while high.
REQ-008 i_frame_sync  input  1  one-cycle pulse marking frame start.
REQ-009 i_pixel_valid  input  1  pixel strobe from the camera.
REQ-010 o_cnn_start  output  1  one-cycle start pulse to the CNN.
REQ-011 i_cnn_valid  input  1  CNN result strobe.
REQ-012 i_cnn_error  input  48 signed  CNN lane error.
REQ-013 o_pid_valid  output  1  one-cycle strobe to the PID controller.
REQ-014 o_pid_error  output  48 signed  clamped error to the PID controller.
REQ-015 o_busy  output  1  high in any state other than IDLE or FAULT.
REQ-016 o_timeout  output  1  one-cycle pulse on each timeout.
REQ-017 o_fault  output  1  high while in FAULT.
REQ-018 o_frame_cnt  output  16  count of completed frames; wraps 0xFFFF->0.

Function
REQ-019 The FSM SHALL have the states IDLE, CAPTURE, WAIT_RESULT and FAULT.
REQ-020 In IDLE, when i_enable=1 and i_frame_sync=1, the block SHALL assert o_cnn_start for exactly the next cycle, clear the pixel counter and enter CAPTURE.
REQ-021 In CAPTURE, the block SHALL count i_pixel_valid; the count reaching FRAME_PIXELS SHALL move the FSM to WAIT_RESULT and clear the timer.
REQ-022 i_frame_sync outside IDLE SHALL be ignored, and pixels arriving in WAIT_RESULT SHALL be ignored.
REQ-023 In WAIT_RESULT, i_cnn_valid SHALL latch i_cnn_error saturated to [-ERR_LIMIT, +ERR_LIMIT], clear the miss counter, increment o_frame_cnt and return to IDLE.
REQ-024 o_pid_valid SHALL pulse one cycle after the accepted i_cnn_valid, with o_pid_error stable from that cycle until the next update.
REQ-025 i_cnn_valid outside WAIT_RESULT SHALL be ignored.
REQ-026 When the timer reaches TIMEOUT_CYCLES in WAIT_RESULT, o_timeout SHALL pulse, the miss counter SHALL increment, and the FSM SHALL go to IDLE.
REQ-027 If the timeout brings the miss counter to MAX_MISSES, the FSM SHALL go to FAULT instead of IDLE.
REQ-028 If i_cnn_valid arrives in the same cycle the timer expires, the result SHALL win and no timeout SHALL be signalled.
REQ-029 i_enable=0 in CAPTURE or WAIT_RESULT SHALL abort to IDLE on the next edge with no o_pid_valid; o_pid_error SHALL hold.
REQ-030 FAULT SHALL exit to IDLE only when i_enable=0 or on reset; the miss counter SHALL clear on that exit.
REQ-031 Saturation SHALL compare in 48-bit signed arithmetic with no wrap-around.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-033 On rst, o_pid_error SHALL be 0 and o_cnn_start, o_pid_valid, o_busy, o_timeout, o_fault and o_frame_cnt SHALL all be 0.
REQ-034 rst asserted mid-frame SHALL discard the frame with no output pulse.

Configuration
REQ-035 With SEQ_HOLD_LAST_EN defined, each timeout that does not enter FAULT SHALL also pulse o_pid_valid one cycle later, re-issuing the last o_pid_error.
REQ-036 Without SEQ_HOLD_LAST_EN, a timeout SHALL raise o_timeout only, with no o_pid_valid.

Structure
REQ-037 Package drive_seq_pkg SHALL hold the state enum, ERR_W=48 and FRAME_CNT_W=16.
REQ-038 Sub-module err_clamp SHALL implement the signed saturation and be instantiated once.

Verification
REQ-039 Bench parameters SHALL be FRAME_PIXELS=16, TIMEOUT_CYCLES=20, ERR_LIMIT=1000 and MAX_MISSES=3.
REQ-040 Nominal case: sync, 16 pixels, then i_cnn_valid with error=-250 at 5 cycles after the last pixel -> one o_cnn_start, o_pid_valid one cycle later with -250, o_frame_cnt=1.
REQ-041 Clamp case: errors +5000 and -5000 -> o_pid_error=+1000 and -1000.
REQ-042 Timeout case: no result after the frame -> o_timeout on cycle 20; o_pid_valid with the previous value only when SEQ_HOLD_LAST_EN is defined.
REQ-043 Fault case: three consecutive timeouts -> o_fault=1 and further syncs ignored; i_enable=0 -> IDLE with o_fault=0.
REQ-044 Collision and abort case: i_cnn_valid on the expiry cycle -> result accepted with no o_timeout; i_enable dropped at pixel 8 -> IDLE with no o_pid_valid.
REQ-045 Reset case: rst during WAIT_RESULT -> all outputs 0 and a late i_cnn_valid ignored.
